flag_capture_multi: RTL and testbench

- Parametrised successor to the byte-entry flag-check block for the Flag Vending Machine FPGA design.
- Accepts a FLAG_LEN-byte secret one byte per debounced BTNL press from SW, and compares it on the fly against a SECRET parameter.
- Reports progress and pass/fail on disp, supports clear via BTNR, and enforces an attempt limit with timed lockout.
- Sits between the board switch/button pins and the LED/7-seg display driver.

---
 rtl/flag_capture_multi_if.sv | 19 +
 rtl/flag_capture_multi.sv | 176 +++++++++++++++++
 tb/tb_flag_capture_multi.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_capture_multi_if.sv
// Board-side signals of the flag entry block: button/switch inputs and status outputs.
// The slave modport is the design side; master is whoever drives the buttons.
interface flag_capture_multi_if #(
  parameter int DATA_W   = 8,
  parameter int FLAG_LEN = 38
);
  localparam int IDX_W = $clog2(FLAG_LEN + 1);

  logic              BTNL;
  logic              BTNR;
  logic [DATA_W-1:0] SW;
  logic [7:0]        disp;
  logic [IDX_W-1:0]  idx;
  logic              pass;
  logic              locked;

  modport master (output BTNL, BTNR, SW, input disp, idx, pass, locked);
  modport slave  (input BTNL, BTNR, SW, output disp, idx, pass, locked);
endinterface

// File: rtl/flag_capture_multi.sv
// Flag entry checker: debounced buttons feed an on-the-fly comparison of FLAG_LEN
// entered symbols against SECRET, with attempt counting and a timed lockout.
module flag_capture_multi #(
  parameter int                         DATA_W    = 8,
  parameter int                         FLAG_LEN  = 38,
  parameter logic [FLAG_LEN*DATA_W-1:0] SECRET    = '0,
  parameter int                         DEB_CYC   = 4,
  parameter int                         MAX_TRIES = 3,
  parameter int                         LOCK_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  flag_capture_multi_if.slave  bus
);
  localparam int IDX_W = $clog2(FLAG_LEN + 1);
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_PASS,
    ST_FAIL,
    ST_LOCK
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 = BTNL, bit 1 = BTNR.
  // ---------------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync0, sync1;
  logic [1:0]       deb;
  logic [1:0]       press;
  logic [CNT_W-1:0] deb_cnt [2];

  assign btn_raw = {bus.BTNR, bus.BTNL};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= '0;
      sync1 <= '0;
      deb   <= '0;
      press <= '0;
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so sync1 takes the pre-edge sync0
      // and the pair behaves as two real flops rather than collapsing into one.
      sync0 <= btn_raw;
      sync1 <= sync0;
      for (int b = 0; b < 2; b++) begin
        press[b] <= 1'b0;
        if (sync1[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == CNT_W'(DEB_CYC - 1)) begin
          deb[b]     <= sync1[b];
          deb_cnt[b] <= '0;
          press[b]   <= sync1[b];
        end else begin
          deb_cnt[b] <= deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  logic press_l, press_r;
  assign press_r = press[1];
  assign press_l = press[0] & ~press[1];  // a clear in the same cycle discards the entry

  // Secret symbols padded to the full idx range so idx indexes without truncation.
  logic [DATA_W-1:0] secret_sym [2**IDX_W];
  for (genvar k = 0; k < 2**IDX_W; k++) begin : g_sym
    if (k < FLAG_LEN) begin : g_real
      assign secret_sym[k] = SECRET[k*DATA_W +: DATA_W];
    end else begin : g_pad
      assign secret_sym[k] = '0;
    end
  end

  logic [7:0] echo;
  if (DATA_W >= 8) begin : g_trunc
    assign echo = bus.SW[7:0];
  end else begin : g_ext
    assign echo = {{(8 - DATA_W){1'b0}}, bus.SW};
  end

  // ---------------------------------------------------------------------------
  // Entry / check / lockout FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e           state;
  logic [IDX_W-1:0] idx_q;
  logic             mismatch;
  logic [TRY_W-1:0] tries;
  logic [LCK_W-1:0] lock_cnt;
  logic [7:0]       disp_q;
  logic             pass_q;
  logic             locked_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ENTRY;
      idx_q    <= '0;
      mismatch <= 1'b0;
      tries    <= '0;
      lock_cnt <= '0;
      disp_q   <= 8'h00;
      pass_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (press_r) begin
            idx_q    <= '0;
            mismatch <= 1'b0;
            disp_q   <= 8'h00;
          end else if (press_l) begin
            mismatch <= mismatch | (bus.SW != secret_sym[idx_q]);
            idx_q    <= idx_q + 1'b1;
            disp_q   <= echo;
            if (idx_q == IDX_W'(FLAG_LEN - 1)) state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (!mismatch) begin
            state  <= ST_PASS;
            tries  <= '0;
            pass_q <= 1'b1;
            disp_q <= 8'hA5;
          end else begin
            tries <= tries + 1'b1;
            if (tries == TRY_W'(MAX_TRIES - 1)) begin
              state    <= ST_LOCK;
              locked_q <= 1'b1;
              disp_q   <= 8'hFF;
              lock_cnt <= LCK_W'(LOCK_CYC - 1);
            end else begin
              state  <= ST_FAIL;
              disp_q <= 8'hEE;
            end
          end
        end

        ST_PASS, ST_FAIL: begin
          if (press_r) begin
            state    <= ST_ENTRY;
            idx_q    <= '0;
            mismatch <= 1'b0;
            disp_q   <= 8'h00;
            pass_q   <= 1'b0;
          end
        end

        ST_LOCK: begin
          if (lock_cnt == '0) begin
            state    <= ST_ENTRY;
            tries    <= '0;
            idx_q    <= '0;
            mismatch <= 1'b0;
            disp_q   <= 8'h00;
            locked_q <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        default: state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.disp   = disp_q;
  assign bus.idx    = idx_q;
  assign bus.pass   = pass_q;
  assign bus.locked = locked_q;
endmodule

// File: tb/tb_flag_capture_multi.sv
// Directed plus randomized bench for flag_capture_multi; a queue-based model of an
// attempt predicts disp/idx/pass/locked, and a monitor times every lockout.
module tb_flag_capture_multi;
  localparam int          DATA_W    = 8;
  localparam int          FLAG_LEN  = 4;
  localparam int          DEB_CYC   = 2;
  localparam int          MAX_TRIES = 3;
  localparam int          LOCK_CYC  = 16;
  localparam logic [31:0] SECRET    = 32'h44434241;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flag_capture_multi_if #(.DATA_W(DATA_W), .FLAG_LEN(FLAG_LEN)) bus ();

  flag_capture_multi #(
    .DATA_W(DATA_W), .FLAG_LEN(FLAG_LEN), .SECRET(SECRET),
    .DEB_CYC(DEB_CYC), .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an attempt is just the list of symbols typed so far.
  typedef enum {M_ENTRY, M_PASS, M_FAIL, M_LOCK} mphase_e;
  mphase_e    m_phase;
  logic [7:0] m_q[$];
  int         m_tries;
  logic [7:0] m_disp;
  int         m_locks_exp = 0;
  int         locks_seen  = 0;
  int         lock_run    = 0;

  function automatic logic [7:0] sec_byte(input int k);
    logic [31:0] s;
    s = SECRET;
    return s[k*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_ENTRY;
    m_q.delete();
    m_tries = 0;
    m_disp  = 8'h00;
  endtask

  task automatic model_l(input logic [7:0] sym);
    bit ok;
    if (m_phase != M_ENTRY) return;
    m_q.push_back(sym);
    m_disp = sym;
    if (m_q.size() == FLAG_LEN) begin
      ok = 1'b1;
      foreach (m_q[k]) if (m_q[k] != sec_byte(k)) ok = 1'b0;
      if (ok) begin
        m_phase = M_PASS;
        m_disp  = 8'hA5;
        m_tries = 0;
      end else begin
        m_tries++;
        if (m_tries == MAX_TRIES) begin
          m_phase = M_LOCK;
          m_disp  = 8'hFF;
          m_locks_exp++;
        end else begin
          m_phase = M_FAIL;
          m_disp  = 8'hEE;
        end
      end
    end
  endtask

  task automatic model_r();
    if (m_phase == M_LOCK) return;
    m_phase = M_ENTRY;
    m_q.delete();
    m_disp = 8'h00;
  endtask

  task automatic model_unlock();
    model_reset();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " disp"},   bus.disp, m_disp);
    check({tag, " idx"},    bus.idx, m_q.size());
    check({tag, " pass"},   bus.pass, m_phase == M_PASS);
    check({tag, " locked"}, bus.locked, m_phase == M_LOCK);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic r, input logic [7:0] sym,
                       input int hold, input int gap);
    bus.SW   = sym;
    bus.BTNL = l;
    bus.BTNR = r;
    cyc(hold);
    bus.BTNL = 1'b0;
    bus.BTNR = 1'b0;
    cyc(gap);
  endtask

  // A 40-cycle press outlasts a whole lockout, so a lock it triggers has ended by return.
  task automatic enter(input logic [7:0] sym, input string tag);
    drive(1'b1, 1'b0, sym, 20, 20);
    model_l(sym);
    if (m_phase == M_LOCK) model_unlock();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic clear(input string tag);
    drive(1'b0, 1'b1, 8'h00, 20, 20);
    model_r();
    @(negedge clk);
    check_outputs(tag);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("idx_bound", bus.idx <= FLAG_LEN, 1);
      if (bus.locked) begin
        lock_run++;
        check("lock_disp", bus.disp, 8'hFF);
      end else if (lock_run != 0) begin
        locks_seen++;
        check("lock_len", lock_run, LOCK_CYC);
        lock_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sym;
    bus.BTNL = 1'b0;
    bus.BTNR = 1'b0;
    bus.SW   = '0;
    model_reset();

    #2 rst = 1'b0;
    #1 check_outputs("reset");
    cyc(3);
    @(negedge clk) rst = 1'b1;
    cyc(2);

    // Correct entry, then clear.
    enter(8'h41, "ok1"); enter(8'h42, "ok2"); enter(8'h43, "ok3"); enter(8'h44, "ok4");
    clear("clr_pass");

    // Third symbol wrong -> FAIL, tries 1.
    enter(8'h41, "bad1"); enter(8'h42, "bad2"); enter(8'h58, "bad3"); enter(8'h44, "bad4");
    clear("clr_fail");

    // Second failure, then a third that triggers lockout.
    for (int i = 0; i < FLAG_LEN; i++) enter(8'h00, "zero");
    clear("clr_fail2");
    enter(8'h11, "w1"); enter(8'h22, "w2"); enter(8'h33, "w3");
    drive(1'b1, 1'b0, 8'h44, 6, 0);
    for (int i = 0; i < 30 && !bus.locked; i++) cyc(1);
    model_l(8'h44);
    @(negedge clk);
    check_outputs("lock_entry");
    cyc(5);
    drive(1'b1, 1'b0, 8'h41, 3, 0);   // pressed and released entirely inside the lock
    for (int i = 0; i < 40 && bus.locked; i++) cyc(1);
    check("lock_exit", bus.locked, 1'b0);
    model_unlock();
    cyc(10);
    @(negedge clk);
    check_outputs("after_lock");

    // tries was cleared by the lockout: one more failure must not relock.
    for (int i = 0; i < FLAG_LEN; i++) enter(8'h99, "post_lock");
    clear("clr_post_lock");

    // Debounce: a short glitch is ignored, a long hold is one press.
    drive(1'b1, 1'b0, 8'h41, DEB_CYC - 1, 20);
    @(negedge clk);
    check_outputs("glitch");
    drive(1'b1, 1'b0, 8'h41, 100, 20);
    model_l(8'h41);
    @(negedge clk);
    check_outputs("long_hold");
    clear("clr_hold");

    // Simultaneous presses at idx 2 with a pending mismatch: clear wins.
    enter(8'h58, "sim1"); enter(8'h59, "sim2");
    drive(1'b1, 1'b1, 8'h43, 20, 20);
    model_r();
    @(negedge clk);
    check_outputs("simul");
    enter(8'h41, "sok1"); enter(8'h42, "sok2"); enter(8'h43, "sok3"); enter(8'h44, "sok4");
    clear("clr_simul");

    // Asynchronous reset mid-attempt.
    enter(8'h41, "ar1"); enter(8'h42, "ar2");
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk) rst = 1'b1;
    cyc(2);
    enter(8'h41, "rr1"); enter(8'h42, "rr2"); enter(8'h43, "rr3"); enter(8'h44, "rr4");
    clear("clr_rr");

    // Randomized attempts, mostly correct symbols with occasional errors and clears.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        clear("rnd_clr");
      end else begin
        if (m_phase == M_ENTRY && $urandom_range(0, 3) != 0)
          sym = sec_byte(m_q.size());
        else
          sym = 8'($urandom);
        enter(sym, "rnd");
      end
    end

    check("locks_seen", locks_seen, m_locks_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
